// File: rtl/rom_test_pkg.sv
// Shared constants, types and the ROM content function for the ROM scan block.
// rom_word is the one place the ROM image is defined.
package rom_test_pkg;

   localparam int ROM_AW    = 9;
   localparam int ROM_DW    = 8;
   localparam int ROM_DEPTH = 2 ** ROM_AW;

   typedef logic [ROM_AW-1:0] rom_addr_t;
   typedef logic [ROM_DW-1:0] rom_word_t;

   // Lower half holds the address byte, upper half its complement.
   function automatic rom_word_t rom_word(input rom_addr_t addr);
      return addr[ROM_AW-1] ? ~addr[ROM_DW-1:0] : addr[ROM_DW-1:0];
   endfunction

endpackage

// File: rtl/rom_scan_test_if.sv
// Bundle of the ROM scan observation nets, for capture/monitor logic.
// master drives the nets, slave only observes them.
interface rom_scan_test_if;
   import rom_test_pkg::*;

   rom_addr_t   rom_addr;
   rom_word_t   rom_data;
   logic        rom_valid;
   logic [15:0] err_cnt;
   logic        err_flag;

   modport master (output rom_addr, rom_data, rom_valid, err_cnt, err_flag);
   modport slave  (input  rom_addr, rom_data, rom_valid, err_cnt, err_flag);

endinterface

// File: rtl/rom_512x8.sv
// 512x8 synchronous-read ROM; dout is the registered read data (rom_data).
// The image is a constant table built from rom_word so it maps onto block RAM.
module rom_512x8
   import rom_test_pkg::*;
(
   input  logic      clk,
   input  rom_addr_t addr,
   output rom_word_t dout
);

   rom_word_t mem [ROM_DEPTH];

   for (genvar a = 0; a < ROM_DEPTH; a++) begin : g_img
      assign mem[a] = rom_word(rom_addr_t'(a));
   end

   always_ff @(posedge clk) begin
      dout <= mem[addr];
   end

endmodule

// File: rtl/rom_scan_test.sv
// Free-running ROM sweep with registered read data for debug capture.
// Optional self-check (mismatch counter and sticky flag) under `ifdef ROM_SELF_CHECK_EN.
module rom_scan_test
   import rom_test_pkg::*;
#(
   parameter int ADDR_W = ROM_AW,
   parameter int DATA_W = ROM_DW
)
(
   input logic sys_clk,
   input logic rst_n
);

   logic [ADDR_W-1:0] rom_addr;
   logic [ADDR_W-1:0] rom_rd_addr;
   logic [DATA_W-1:0] rom_data;
   logic              rom_valid;
   logic [15:0]       err_cnt;
   logic              err_flag;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         rom_addr  <= '0;
         rom_valid <= 1'b0;
      end else begin
         rom_addr  <= rom_addr + ADDR_W'(1);
         rom_valid <= 1'b1;
      end
   end

   // Steering the read to word 0 in reset clears rom_data without a reset on the RAM port.
   assign rom_rd_addr = rst_n ? rom_addr : '0;

   rom_512x8 u_rom (
      .clk  (sys_clk),
      .addr (rom_rd_addr),
      .dout (rom_data)
   );

`ifdef ROM_SELF_CHECK_EN
   logic [ADDR_W-1:0] exp_addr;
   logic              mismatch;

   assign mismatch = rom_valid && (rom_data != rom_word(exp_addr));

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         exp_addr <= '0;
         err_cnt  <= '0;
         err_flag <= 1'b0;
      end else begin
         exp_addr <= rom_addr;
         if (mismatch) begin
            err_cnt  <= sat_inc(err_cnt);
            err_flag <= 1'b1;
         end
      end
   end

   always @(posedge sys_clk) begin
      if (rst_n) begin
         assert (!(mismatch && !err_flag))
            else $error("rom_scan_test: first mismatch at exp_addr %0h data %0h", exp_addr, rom_data);
      end
   end
`else
   assign err_cnt  = '0;
   assign err_flag = 1'b0;
`endif

   // The observation nets have no load on the board; fold them into one sink.
   logic unused_dbg;
   assign unused_dbg = ^{rom_data, rom_valid, err_cnt, err_flag, sat_inc(16'd0)};

endmodule

// File: tb/tb_rom_scan_test.sv
// Scoreboard bench for rom_scan_test: stimulus pushes the expected observation state
// per cycle, a negedge monitor pops and compares. Covers ROM_SELF_CHECK_EN when defined.
module tb_rom_scan_test;

   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;

   always #10 sys_clk = ~sys_clk;

   rom_scan_test dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n)
   );

   rom_scan_test_if dbg ();
   assign dbg.rom_addr  = dut.rom_addr;
   assign dbg.rom_data  = dut.rom_data;
   assign dbg.rom_valid = dut.rom_valid;
   assign dbg.err_cnt   = dut.err_cnt;
   assign dbg.err_flag  = dut.err_flag;

   typedef struct {
      logic [8:0]  addr;
      logic [7:0]  data;
      logic        valid;
      logic [15:0] cnt;
      logic        flag;
      string       tag;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   // Expected ROM image written from the spec table: a for a<256, 511-a above.
   function automatic logic [7:0] ref_word(input int a);
      if (a < 256) return 8'(a);
      else         return 8'(511 - a);
   endfunction

   int         m_addr  = 0;
   logic [7:0] m_data  = 8'h00;
   bit         m_valid = 1'b0;
   int         m_exp   = 0;
   int         m_cnt   = 0;
   bit         m_flag  = 1'b0;
   bit         m_force = 1'b0;
   bit         forced_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cycle(input bit rst_val, input bit do_force);
      exp_t       e;
      logic [7:0] obs;
      @(negedge sys_clk);
      rst_n = rst_val;
      @(posedge sys_clk);
      if (!rst_val) begin
         m_addr = 0; m_data = 8'h00; m_valid = 1'b0;
         m_exp  = 0; m_cnt  = 0;     m_flag  = 1'b0;
      end else begin
         obs = m_force ? 8'h5A : m_data;
`ifdef ROM_SELF_CHECK_EN
         if (m_valid && (obs != ref_word(m_exp))) begin
            if (m_cnt < 65535) m_cnt++;
            m_flag = 1'b1;
         end
         m_exp = m_addr;
`endif
         m_data  = ref_word(m_addr);
         m_addr  = (m_addr + 1) % 512;
         m_valid = 1'b1;
      end
      #1;
`ifdef ROM_SELF_CHECK_EN
      if (do_force)     force dut.rom_data = 8'h5A;
      else if (m_force) release dut.rom_data;
`endif
      m_force = do_force;
      e.addr  = 9'(m_addr);
      e.data  = m_force ? 8'h5A : m_data;
      e.valid = m_valid;
      e.cnt   = 16'(m_cnt);
      e.flag  = m_flag;
      e.tag   = rst_val ? "scan" : "reset";
      // Hand-computed points around the half boundary and the wrap.
      if (m_valid && !m_force) begin
         case (m_addr)
            9'h100: begin e.data = 8'hFF; e.tag = "at_x100"; end
            9'h101: begin e.data = 8'hFF; e.tag = "at_x101"; end
            9'h000: begin e.data = 8'h00; e.tag = "wrap_0";  end
            9'h001: begin e.data = 8'h00; e.tag = "addr_1";  end
            default: ;
         endcase
      end
      sbq.push_back(e);
   endtask

   always @(negedge sys_clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({e.tag, ".addr"},  32'(dbg.rom_addr),  32'(e.addr));
         chk({e.tag, ".data"},  32'(dbg.rom_data),  32'(e.data));
         chk({e.tag, ".valid"}, 32'(dbg.rom_valid), 32'(e.valid));
         chk({e.tag, ".cnt"},   32'(dbg.err_cnt),   32'(e.cnt));
         chk({e.tag, ".flag"},  32'(dbg.err_flag),  32'(e.flag));
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
      for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 220; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 600 && m_addr != 200; i++) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 520; i++) cycle(1'b1, 1'b0);
`ifdef ROM_SELF_CHECK_EN
      for (int i = 0; i < 2000; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < 1200; i++) begin
         if (!forced_done && m_addr == 9) begin
            cycle(1'b1, 1'b1);
            forced_done = 1'b1;
         end else begin
            cycle(1'b1, 1'b0);
         end
      end
`endif
      @(negedge sys_clk);
      @(negedge sys_clk);
      #5;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
